// File: rtl/neopx_bit_tx_if.sv
// Pixel-word stream between the Wishbone NeoPixel controller (master) and the
// WS2812 serializer (slave). Plain valid/ready handshake with no skid buffer.
interface neopx_bit_tx_if;
  logic [31:0] data;   // [23:0] = G R B, [31:24] unused
  logic        valid;
  logic        ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/neopx_bit_tx.sv
// WS2812 one-wire serializer: shifts 24-bit GRB words MSB first and reports the strip latch.
// Optional NEOPX_OUT_INVERT_EN inverts o_neopx to drive an inverting level shifter.
module neopx_bit_tx #(
  parameter int unsigned T0H_CYCLES   = 29,
  parameter int unsigned T0L_CYCLES   = 61,
  parameter int unsigned T1H_CYCLES   = 58,
  parameter int unsigned T1L_CYCLES   = 32,
  parameter int unsigned RESET_CYCLES = 3600
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  neopx_bit_tx_if.slave  s_axis,
  output logic           o_neopx,
  output logic           o_busy,
  output logic           o_latched,
  output logic           o_drop
);

  localparam logic [15:0] T0H_LAST  = 16'(T0H_CYCLES - 1);
  localparam logic [15:0] T0L_LAST  = 16'(T0L_CYCLES - 1);
  localparam logic [15:0] T1H_LAST  = 16'(T1H_CYCLES - 1);
  localparam logic [15:0] T1L_LAST  = 16'(T1L_CYCLES - 1);
  localparam logic [15:0] LATCH_VAL = 16'(RESET_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [23:0] r_shift;
  logic [4:0]  r_bit_idx;
  logic [15:0] r_cnt;
  logic [15:0] r_lat_cnt;
  logic        r_drop;
  logic        w_accept;
  logic        w_phase_end;
  logic        w_line;
  logic [15:0] w_phase_last;
  logic        w_unused_data;

  assign w_unused_data = ^s_axis.data[31:24];

  // Phase length is picked by the bit currently at the top of the shift register.
  assign w_phase_last = (r_state == HIGH) ? (r_shift[23] ? T1H_LAST : T0H_LAST)
                                          : (r_shift[23] ? T1L_LAST : T0L_LAST);
  assign w_phase_end  = (r_cnt == w_phase_last);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_axis.valid) begin
          w_accept    = 1'b1;
          w_state_nxt = HIGH;
        end
      end
      HIGH: if (w_phase_end) w_state_nxt = LOW;
      LOW:  if (w_phase_end) w_state_nxt = (r_bit_idx != 5'd0) ? HIGH : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: all state here is plain flops, so the synchronous reset covers every register.
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_cnt     <= '0;
      r_lat_cnt <= '0;
      r_drop    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      r_state <= w_state_nxt;
      r_drop  <= s_axis.valid && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift   <= s_axis.data[23:0];
            r_bit_idx <= 5'd23;
            r_cnt     <= '0;
            r_lat_cnt <= '0;
          end else if (r_lat_cnt != LATCH_VAL) begin
            r_lat_cnt <= r_lat_cnt + 16'd1;
          end
        end
        HIGH: r_cnt <= w_phase_end ? 16'd0 : r_cnt + 16'd1;
        LOW: begin
          if (w_phase_end) begin
            r_cnt <= '0;
            if (r_bit_idx != 5'd0) begin
              r_shift   <= {r_shift[22:0], 1'b0};
              r_bit_idx <= r_bit_idx - 5'd1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_line       = (r_state == HIGH);
  assign s_axis.ready = (r_state == IDLE);
  assign o_busy       = (r_state != IDLE);
  assign o_latched    = (r_lat_cnt == LATCH_VAL);
  assign o_drop       = r_drop;

`ifdef NEOPX_OUT_INVERT_EN
  assign o_neopx = ~w_line;
`else
  assign o_neopx = w_line;
`endif

endmodule

// File: tb/tb_neopx_bit_tx.sv
// Directed bench for neopx_bit_tx: measures every bit's high/low width against
// hand-derived GRB words, plus latch timing, drop pulses and mid-pixel reset.
module tb_neopx_bit_tx;

  localparam int T0H = 29;
  localparam int T0L = 61;
  localparam int T1H = 58;
  localparam int T1L = 32;
  localparam int RST_CYC = 3600;
`ifdef NEOPX_OUT_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic o_neopx, o_busy, o_latched, o_drop;
  logic line_lvl;
  int   n_vec = 0;
  int   n_miss = 0;

  neopx_bit_tx_if u_if ();

  neopx_bit_tx dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .s_axis    (u_if),
    .o_neopx   (o_neopx),
    .o_busy    (o_busy),
    .o_latched (o_latched),
    .o_drop    (o_drop)
  );

  always #5 clk = ~clk;

  // Logical line level regardless of output polarity.
  assign line_lvl = o_neopx ^ INV;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts idle cycles until o_latched rises; the line must stay idle meanwhile.
  task automatic wait_latch(input string tag);
    int k;
    int bad;
    k = 0;
    bad = 0;
    while (!o_latched && k < RST_CYC + 100) begin
      tick();
      k++;
      if (!u_if.ready || line_lvl) bad++;
    end
    check({tag, ".latch_cycles"}, k, RST_CYC);
    check({tag, ".idle_line"}, bad, 0);
  endtask

  // Sends one word with a single-cycle valid and measures all 24 bits.
  // drop_at: bit number (0 = first sent) at which a stray valid is pulsed.
  // rst_at:  bit number during whose high phase reset is pulsed for one cycle.
  task automatic send_and_measure(input logic [31:0] word, input string tag,
                                  input int drop_at, input int rst_at);
    int hi;
    int lo;
    int drop_step;
    int stray;
    logic [23:0] px;
    px = word[23:0];
    u_if.data  = word;
    u_if.valid = 1'b1;
    tick();
    u_if.valid = 1'b0;
    u_if.data  = '0;
    check({tag, ".ready_lo"}, u_if.ready, 0);
    check({tag, ".busy_hi"}, o_busy, 1);
    check({tag, ".latched_lo"}, o_latched, 0);
    drop_step = 0;
    stray = 0;
    for (int b = 0; b < 24; b++) begin
      hi = 0;
      while (line_lvl && hi < 200) begin
        if (o_drop && drop_step != 1) stray++;
        if (drop_step == 1) begin
          check({tag, ".drop_pulse"}, o_drop, 1);
          drop_step = 2;
        end else if (drop_step == 2) begin
          check({tag, ".drop_clear"}, o_drop, 0);
          drop_step = 3;
        end
        u_if.valid = 1'b0;
        if (b == drop_at && hi == 3 && drop_step == 0) begin
          u_if.data  = 32'hFFFF_FFFF;
          u_if.valid = 1'b1;
          drop_step  = 1;
        end
        if (b == rst_at && hi == 5) begin
          rst_n = 1'b0;
          tick();
          rst_n = 1'b1;
          check({tag, ".rst_line"}, o_neopx, INV);
          check({tag, ".rst_ready"}, u_if.ready, 1);
          check({tag, ".rst_busy"}, o_busy, 0);
          check({tag, ".rst_latched"}, o_latched, 0);
          return;
        end
        hi++;
        tick();
      end
      lo = 0;
      while (!line_lvl && o_busy && lo < 200) begin
        if (o_drop) stray++;
        lo++;
        tick();
      end
      check($sformatf("%s.b%0d.hi", tag, b), hi, px[23-b] ? T1H : T0H);
      check($sformatf("%s.b%0d.lo", tag, b), lo, px[23-b] ? T1L : T0L);
    end
    check({tag, ".ready_back"}, u_if.ready, 1);
    check({tag, ".busy_back"}, o_busy, 0);
    check({tag, ".stray_drop"}, stray, 0);
  endtask

  logic [31:0] burst [8];

  initial begin
    burst[0] = 32'h00FF_0000;
    burst[1] = 32'hC300_FF00;
    burst[2] = 32'h0000_00FF;
    burst[3] = 32'h0012_3456;
    burst[4] = 32'h5AFF_FFFF;
    burst[5] = 32'h0000_0000;
    burst[6] = 32'h0080_0001;
    burst[7] = 32'h00A5_5AC3;

    u_if.data  = '0;
    u_if.valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("por.ready", u_if.ready, 1);
    check("por.line", o_neopx, INV);
    check("por.busy", o_busy, 0);
    check("por.drop", o_drop, 0);
    check("por.latched", o_latched, 0);
    rst_n = 1'b1;
    wait_latch("por");

    send_and_measure(32'h00AA_00FF, "px0", -1, -1);
    check("px0.latched_after", o_latched, 0);
    wait_latch("px0");

    for (int i = 0; i < 8; i++) begin
      send_and_measure(burst[i], $sformatf("burst%0d", i), -1, -1);
    end
    check("burst.latched_after", o_latched, 0);
    wait_latch("burst");

    send_and_measure(32'h00AA_00FF, "drop", 5, -1);
    repeat (5) tick();
    check("drop.not_queued", o_busy, 0);

    send_and_measure(32'h0000_55AA, "rst", -1, 10);
    tick();
    send_and_measure(32'h0012_3456, "post_rst", -1, -1);

`ifdef NEOPX_OUT_INVERT_EN
    tick();
    check("inv.idle_level", o_neopx, 1);
    send_and_measure(32'h0080_0000, "inv", -1, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
